keypad_decoder: RTL and testbench
=================================

// Module: keypad_decoder
// PURPOSE
//  Downstream of the keypad row-sampling stage. Assembles the per-column row samples of one
//  4x4 keypad scan into a frame and debounces across frames. Emits one registered key code
//  with a single-cycle valid pulse per press, plus held and multi-key status.
//  Feeds digit-entry / control logic.
// PARAMETERS
//  STABLE_SCANS   3   consecutive identical single-key frames required to accept a press (>=1)
//  RELEASE_SCANS  2   consecutive empty frames required to accept a release (>=1)
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset        in   1  asynchronous, active-high reset
//  col          in   4  one-hot active column from column FSM; bit i = column i; scan order 1000,0100,0010,0001
//  sample       in   4  synchronised row bits for the active column; bit j = row j, 1 = pressed
//  col_strobe   in   1  1-cycle pulse: col/sample valid for this column
//  key_code     out  4  code of last accepted key
//  key_valid    out  1  1-cycle pulse, new key accepted
//  key_held     out  1  1 while accepted key is still down
//  multi_key    out  1  1 if last completed frame had >=2 pressed keys
// BEHAVIOUR
//  Reset: state IDLE, frame cleared, all counters 0; key_code=0, key_valid=0, key_held=0, multi_key=0.
//  Frame assembly on each col_strobe:
//   - col not one-hot: set frame_bad.
//   - otherwise add popcount(sample) to hits (2-bit, saturates at 2); if a hit, record (col_idx,row_idx).
//   - strobe with col==0001 ends the frame. frame_done is pulsed next cycle; hits/idx/frame_bad then clear.
//   - bad frame: discarded; FSM and counters unchanged; multi_key unchanged.
//  Key map (row,col) -> code:
//   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: *=E 0 #=F D  (A..D = 0xA..0xD)
//  FSM, evaluated only on frame_done; F = frame result NONE / SINGLE(k) / MULTI:
//   IDLE:     SINGLE(k) -> cand=k, cnt=1. If STABLE_SCANS==1, go straight to ACCEPT; else DEBOUNCE.
//             NONE/MULTI -> stay.
//   DEBOUNCE: SINGLE(cand) -> cnt+1; ACCEPT when cnt reaches STABLE_SCANS.
//             SINGLE(k!=cand) -> cand=k, cnt=1.
//             NONE/MULTI -> IDLE, cnt=0.
//   ACCEPT:   same cycle: key_code<=cand, key_valid<=1 (one cycle), key_held<=1, enter PRESSED, rcnt=0.
//   PRESSED:  NONE -> rcnt+1; at RELEASE_SCANS -> IDLE, key_held<=0.
//             SINGLE(any)/MULTI -> rcnt=0, stay. No rollover: a new key needs a release first.
//  Latency: key_valid is high exactly 2 cycles after the col_strobe ending the STABLE_SCANS-th matching frame.
//  key_held drops 2 cycles after the strobe ending the RELEASE_SCANS-th empty frame.
//  key_code holds its value until the next accept; it is never cleared on release.
//  multi_key is updated every good frame_done (1 iff hits==2).
//  col_strobe coincident with frame_done: the new strobe belongs to the next frame; no loss.
//  Counters are sized for the parameter maxima and saturate; they never wrap.
//  Reset mid-frame or mid-debounce aborts everything; the first frame after reset starts from an empty accumulator.
// STRUCTURE
//  keypad_pkg:
//   - state enum {IDLE, DEBOUNCE, ACCEPT, PRESSED}
//   - frame-result enum {NONE, SINGLE, MULTI}
//   - KEY_* code constants and the 16-entry map function
//  Sub-module keypad_frame_acc: strobe accumulation, one-hot check, outputs frame_done/result/idx/bad.
//  Debounce FSM and output registers live in keypad_decoder.
// TESTING (STABLE_SCANS=3, RELEASE_SCANS=2; bench drives full 4-strobe frames)
//  1 Reset: assert reset mid-frame -> all outputs 0. First post-reset frame alone produces no key_valid.
//  2 Press row1/col2 for 3 frames -> one key_valid pulse, key_code=6, key_held=1.
//    Hold 10 more frames -> no further pulse.
//  3 2 empty frames -> key_held=0, key_code stays 6.
//    Then row3/col0 x3 frames -> key_code=E, key_valid pulse.
//  4 Bounce: k=5,5,none,5,5,5 -> single key_valid, only after the last of the final three 5-frames.
//    k=5,5,8,8,8 -> key_code=8 and no 5 is accepted.
//  5 Two keys in one frame (row0 col0 + row2 col3) -> multi_key=1, no accept, debounce restarts.
//    A 1-frame gap during PRESSED -> key_held remains 1.
//  6 Strobe with col=0110 -> frame discarded; state and multi_key unchanged.
//    col_strobe in cycle after frame end -> counted in the next frame.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and helpers for the 4x4 keypad decoder:
//   - state_t  : debounce FSM states
//   - result_t : per-frame classification (no key / one key / several keys)
//   - KEY_*    : key code constants
//   - key_map  : (row, col) -> key code lookup
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_PRESSED
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } result_t;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Physical layout, row 0 at the top, column 0 at the left:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_frame_acc.sv
// keypad_frame_acc
//   Collects the four per-column row samples of one keypad scan into a frame.
//   Ports:
//     i_clk, i_rst           clock, asynchronous active-high reset
//     i_col[3:0]             one-hot active column (bit i = column i)
//     i_sample[3:0]          row bits for the active column (1 = pressed)
//     i_col_strobe           col/sample valid this cycle
//     o_frame_done           1-cycle pulse after the strobe on column 0
//     o_frame_bad            frame saw a non-one-hot column strobe
//     o_result               NONE / SINGLE / MULTI for the completed frame
//     o_row_idx, o_col_idx   position of the recorded hit
module keypad_frame_acc
  import keypad_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_col,
  input  logic [3:0] i_sample,
  input  logic       i_col_strobe,
  output logic       o_frame_done,
  output logic       o_frame_bad,
  output result_t    o_result,
  output logic [1:0] o_row_idx,
  output logic [1:0] o_col_idx
);

  logic [1:0] r_hits;
  logic [1:0] r_row;
  logic [1:0] r_col;
  logic       r_bad;

  logic       w_onehot;
  logic       w_end;
  logic [2:0] w_pop;
  logic [2:0] w_sum;
  logic [1:0] w_hits_next;
  logic [1:0] w_row_hit;
  logic [1:0] w_col_enc;
  logic [1:0] w_row_next;
  logic [1:0] w_col_next;
  result_t    w_result;

  assign w_onehot = (i_col != 4'b0000) && ((i_col & (i_col - 4'd1)) == 4'b0000);
  assign w_end    = (i_col == 4'b0001);
  assign w_pop    = {2'b00, i_sample[0]} + {2'b00, i_sample[1]}
                  + {2'b00, i_sample[2]} + {2'b00, i_sample[3]};
  assign w_sum    = {1'b0, r_hits} + w_pop;

  always_comb begin
    w_row_hit = 2'd0;
    if (i_sample[0])      w_row_hit = 2'd0;
    else if (i_sample[1]) w_row_hit = 2'd1;
    else if (i_sample[2]) w_row_hit = 2'd2;
    else if (i_sample[3]) w_row_hit = 2'd3;

    w_col_enc = 2'd0;
    case (i_col)
      4'b0010: w_col_enc = 2'd1;
      4'b0100: w_col_enc = 2'd2;
      4'b1000: w_col_enc = 2'd3;
      default: w_col_enc = 2'd0;
    endcase

    // A malformed column strobe contributes nothing but poisons the frame.
    w_hits_next = r_hits;
    w_row_next  = r_row;
    w_col_next  = r_col;
    if (w_onehot) begin
      w_hits_next = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
      if (w_pop != 3'd0) begin
        w_row_next = w_row_hit;
        w_col_next = w_col_enc;
      end
    end

    case (w_hits_next)
      2'd0:    w_result = RES_NONE;
      2'd1:    w_result = RES_SINGLE;
      default: w_result = RES_MULTI;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hits       <= 2'd0;
      r_row        <= 2'd0;
      r_col        <= 2'd0;
      r_bad        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_bad  <= 1'b0;
      o_result     <= RES_NONE;
      o_row_idx    <= 2'd0;
      o_col_idx    <= 2'd0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_col_strobe) begin
        if (w_end) begin
          // Publish the finished frame and clear the accumulator in the same
          // edge, so a strobe in the following cycle starts the next frame.
          o_frame_done <= 1'b1;
          o_frame_bad  <= r_bad;
          o_result     <= w_result;
          o_row_idx    <= w_row_next;
          o_col_idx    <= w_col_next;
          r_hits       <= 2'd0;
          r_row        <= 2'd0;
          r_col        <= 2'd0;
          r_bad        <= 1'b0;
        end else begin
          r_hits <= w_hits_next;
          r_row  <= w_row_next;
          r_col  <= w_col_next;
          r_bad  <= r_bad | ~w_onehot;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder
//   Debounces complete keypad frames and reports accepted key presses.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     col[3:0]        one-hot active column, scan order 1000,0100,0010,0001
//     sample[3:0]     row bits for the active column (1 = pressed)
//     col_strobe      col/sample valid this cycle
//     key_code[3:0]   code of the last accepted key (kept across release)
//     key_valid       1-cycle pulse when a new key is accepted
//     key_held        1 while the accepted key is still down
//     multi_key       last good frame contained two or more pressed keys
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned STABLE_SCANS  = 3,
  parameter int unsigned RELEASE_SCANS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  input  logic [3:0] sample,
  input  logic       col_strobe,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned CNT_W  = $clog2(STABLE_SCANS + 1);
  localparam int unsigned RCNT_W = $clog2(RELEASE_SCANS + 1);
  localparam logic [CNT_W-1:0]  STABLE_MAX  = CNT_W'(STABLE_SCANS);
  localparam logic [RCNT_W-1:0] RELEASE_MAX = RCNT_W'(RELEASE_SCANS);

  logic       w_frame_done;
  logic       w_frame_bad;
  result_t    w_result;
  logic [1:0] w_row_idx;
  logic [1:0] w_col_idx;
  logic       w_good;
  logic [3:0] w_key;

  state_t            r_state;
  logic [3:0]        r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [RCNT_W-1:0] r_rcnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [RCNT_W-1:0] w_rcnt_inc;

  keypad_frame_acc u_frame_acc (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_col        (col),
    .i_sample     (sample),
    .i_col_strobe (col_strobe),
    .o_frame_done (w_frame_done),
    .o_frame_bad  (w_frame_bad),
    .o_result     (w_result),
    .o_row_idx    (w_row_idx),
    .o_col_idx    (w_col_idx)
  );

  assign w_good     = w_frame_done & ~w_frame_bad;
  assign w_key      = key_map(w_row_idx, w_col_idx);
  // Saturating increments: the counters can never wrap back to zero.
  assign w_cnt_inc  = (r_cnt  == STABLE_MAX)  ? r_cnt  : r_cnt  + CNT_W'(1);
  assign w_rcnt_inc = (r_rcnt == RELEASE_MAX) ? r_rcnt : r_rcnt + RCNT_W'(1);

  // The accept outputs are registered on the edge that enters ST_ACCEPT, so
  // key_valid appears two cycles after the strobe that closed the frame.
  // ST_ACCEPT itself only lasts one cycle, which bounds key_valid to a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cand    <= 4'h0;
      r_cnt     <= '0;
      r_rcnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (w_good) multi_key <= (w_result == RES_MULTI);

      case (r_state)
        ST_IDLE: begin
          if (w_good && w_result == RES_SINGLE) begin
            r_cand <= w_key;
            r_cnt  <= CNT_W'(1);
            if (STABLE_SCANS == 1) begin
              r_state   <= ST_ACCEPT;
              key_code  <= w_key;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              r_rcnt    <= '0;
            end else begin
              r_state <= ST_DEBOUNCE;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (w_good) begin
            if (w_result == RES_SINGLE && w_key == r_cand) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == STABLE_MAX) begin
                r_state   <= ST_ACCEPT;
                key_code  <= r_cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_rcnt    <= '0;
              end
            end else if (w_result == RES_SINGLE) begin
              r_cand <= w_key;
              r_cnt  <= CNT_W'(1);
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
        end

        ST_ACCEPT: begin
          r_state <= ST_PRESSED;
          r_rcnt  <= '0;
        end

        ST_PRESSED: begin
          // Any key activity, even a different key, restarts the release
          // count; a new key is only accepted after a full release.
          if (w_good) begin
            if (w_result == RES_NONE) begin
              if (w_rcnt_inc == RELEASE_MAX) begin
                r_state  <= ST_IDLE;
                key_held <= 1'b0;
                r_rcnt   <= '0;
                r_cnt    <= '0;
              end else begin
                r_rcnt <= w_rcnt_inc;
              end
            end else begin
              r_rcnt <= '0;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col;
  logic [3:0] sample;
  logic       col_strobe;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  keypad_decoder #(.STABLE_SCANS(3), .RELEASE_SCANS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .col        (col),
    .sample     (sample),
    .col_strobe (col_strobe),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_key  (multi_key)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_end = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every key_valid pulse must match the next queued expectation,
  // both in code and in the exact cycle it appears.
  always @(negedge clk) begin : mon
    exp_t e;
    if (key_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL key_valid: unexpected pulse code=%0h cycle=%0d, want no pulse", key_code, cyc);
      end else begin
        e = sb.pop_front();
        if (key_code !== e.code || cyc != e.at) begin
          bad++;
          $display("FAIL key_valid: got code=%0h cycle=%0d want code=%0h cycle=%0d",
                   key_code, cyc, e.code, e.at);
        end
      end
    end
  end

  task automatic strobe(input logic [3:0] c, input logic [3:0] s);
    col = c; sample = s; col_strobe = 1'b1;
    @(posedge clk); #1;
    col_strobe = 1'b0; col = 4'b0000; sample = 4'b0000;
  endtask

  // s3..s0 are the row samples for columns 3..0; the frame ends on column 0.
  task automatic frame(input logic [3:0] s3, input logic [3:0] s2,
                       input logic [3:0] s1, input logic [3:0] s0,
                       input int gap, input bit do_exp, input logic [3:0] code);
    strobe(4'b1000, s3);
    strobe(4'b0100, s2);
    strobe(4'b0010, s1);
    last_end = cyc;
    if (do_exp) sb.push_back('{code: code, at: last_end + 2});
    strobe(4'b0001, s0);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic key_frame(input int row, input int c, input bit do_exp, input logic [3:0] code);
    logic [3:0] s [4];
    for (int i = 0; i < 4; i++) s[i] = 4'b0000;
    s[c][row] = 1'b1;
    frame(s[3], s[2], s[1], s[0], 3, do_exp, code);
  endtask

  task automatic key_frame_gap(input int row, input int c, input int gap,
                               input bit do_exp, input logic [3:0] code);
    logic [3:0] s [4];
    for (int i = 0; i < 4; i++) s[i] = 4'b0000;
    s[c][row] = 1'b1;
    frame(s[3], s[2], s[1], s[0], gap, do_exp, code);
  endtask

  task automatic empty_frame();
    frame(4'b0000, 4'b0000, 4'b0000, 4'b0000, 3, 1'b0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; col = 4'b0000; sample = 4'b0000; col_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset mid-frame, then a lone first frame
    strobe(4'b1000, 4'b0001);
    strobe(4'b0100, 4'b0000);
    #2 reset = 1'b1;
    #1;
    chk("rst1_key_code", key_code, 4'h0);
    chk("rst1_key_valid", {3'b0, key_valid}, 4'h0);
    chk("rst1_key_held", {3'b0, key_held}, 4'h0);
    chk("rst1_multi_key", {3'b0, multi_key}, 4'h0);
    @(posedge clk); #1 reset = 1'b0;
    key_frame(0, 0, 1'b0, 4'h0);
    chk("post_rst_multi", {3'b0, multi_key}, 4'h0);
    chk("post_rst_held", {3'b0, key_held}, 4'h0);
    empty_frame();

    // 2: key 6 accepted after three frames, then held
    key_frame(1, 2, 1'b0, 4'h0);
    key_frame(1, 2, 1'b0, 4'h0);
    key_frame(1, 2, 1'b1, 4'h6);
    chk("k6_code", key_code, 4'h6);
    chk("k6_held", {3'b0, key_held}, 4'h1);
    repeat (10) key_frame(1, 2, 1'b0, 4'h0);
    chk("k6_hold_held", {3'b0, key_held}, 4'h1);

    // 3: release then key E
    empty_frame();
    chk("rel1_held", {3'b0, key_held}, 4'h1);
    empty_frame();
    chk("rel2_held", {3'b0, key_held}, 4'h0);
    chk("rel2_code", key_code, 4'h6);
    key_frame(3, 0, 1'b0, 4'h0);
    key_frame(3, 0, 1'b0, 4'h0);
    key_frame(3, 0, 1'b1, 4'hE);
    chk("kE_code", key_code, 4'hE);

    // 4: bounce patterns
    empty_frame(); empty_frame();
    key_frame(1, 1, 1'b0, 4'h0);
    key_frame(1, 1, 1'b0, 4'h0);
    empty_frame();
    key_frame(1, 1, 1'b0, 4'h0);
    key_frame(1, 1, 1'b0, 4'h0);
    key_frame(1, 1, 1'b1, 4'h5);
    chk("k5_code", key_code, 4'h5);
    empty_frame(); empty_frame();
    key_frame(1, 1, 1'b0, 4'h0);
    key_frame(1, 1, 1'b0, 4'h0);
    key_frame(2, 1, 1'b0, 4'h0);
    key_frame(2, 1, 1'b0, 4'h0);
    key_frame(2, 1, 1'b1, 4'h8);
    chk("k8_code", key_code, 4'h8);
    empty_frame(); empty_frame();

    // 5: two keys in one frame restart debounce; gap while pressed
    key_frame(2, 2, 1'b0, 4'h0);
    key_frame(2, 2, 1'b0, 4'h0);
    frame(4'b0100, 4'b0000, 4'b0000, 4'b0001, 3, 1'b0, 4'h0);
    chk("multi_set", {3'b0, multi_key}, 4'h1);
    key_frame(2, 2, 1'b0, 4'h0);
    chk("multi_clr", {3'b0, multi_key}, 4'h0);
    key_frame(2, 2, 1'b0, 4'h0);
    chk("k9_not_yet", key_code, 4'h8);
    key_frame(2, 2, 1'b1, 4'h9);
    empty_frame();
    chk("gap1_held", {3'b0, key_held}, 4'h1);
    key_frame(2, 2, 1'b0, 4'h0);
    empty_frame();
    chk("gap2_held", {3'b0, key_held}, 4'h1);
    empty_frame();
    chk("k9_rel_held", {3'b0, key_held}, 4'h0);

    // 6: malformed column strobe discards the frame
    key_frame(0, 0, 1'b0, 4'h0);
    key_frame(0, 0, 1'b0, 4'h0);
    strobe(4'b1000, 4'b0000);
    strobe(4'b0110, 4'b0011);
    strobe(4'b0100, 4'b0000);
    strobe(4'b0010, 4'b0000);
    strobe(4'b0001, 4'b0001);
    repeat (3) begin @(posedge clk); #1; end
    chk("bad_multi", {3'b0, multi_key}, 4'h0);
    chk("bad_held", {3'b0, key_held}, 4'h0);
    key_frame(0, 0, 1'b1, 4'h1);
    chk("k1_code", key_code, 4'h1);
    empty_frame(); empty_frame();

    // back-to-back frames: first strobe of a frame coincides with frame_done
    key_frame_gap(0, 3, 0, 1'b0, 4'h0);
    key_frame_gap(0, 3, 0, 1'b0, 4'h0);
    key_frame_gap(0, 3, 3, 1'b1, 4'hA);
    chk("kA_code", key_code, 4'hA);

    // reset while a key is held and a frame is half-assembled
    strobe(4'b1000, 4'b0001);
    strobe(4'b0100, 4'b0000);
    #2 reset = 1'b1;
    #1;
    chk("rst2_key_code", key_code, 4'h0);
    chk("rst2_key_held", {3'b0, key_held}, 4'h0);
    chk("rst2_key_valid", {3'b0, key_valid}, 4'h0);
    @(posedge clk); #1 reset = 1'b0;
    key_frame(0, 0, 1'b0, 4'h0);
    chk("rst2_acc_clear", {3'b0, multi_key}, 4'h0);
    empty_frame();

    repeat (5) begin @(posedge clk); #1; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_pulses: got %0d outstanding want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
